hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
// - Parametrised pipeline hazard controller for the 5-stage MIPS datapath (IF/ID/EX/MEM/WB).
// - Keeps a shift-register scoreboard of in-flight destination registers after decode.
// - Issues a combinational stall (hold PC + IF/ID, bubble into ID/EX) on RAW hazards.
// - Issues a flush when a branch resolves taken, and keeps saturating stall/flush counters.
// PARAMETERS
// - REG_AW    5   register-address width (32 GPRs)
// - STAGES    3   scoreboard entries after decode: idx0=EX, idx1=MEM, ..., idx STAGES-1=WB; min 3
// - BR_STAGE  1   scoreboard index where branch resolves (1=MEM); entries idx<BR_STAGE are younger
// - CNT_W     16  width of the performance counters
// PORTS
// - Eclk       in   1        clock, rising edge
// - Erst       in   1        synchronous reset, active high
// - id_valid   in   1        valid instruction present in ID
// - id_rs      in   REG_AW   ID source register A
// - id_rt      in   REG_AW   ID source register B
// - id_use_rs  in   1        ID instruction reads rs
// - id_use_rt  in   1        ID instruction reads rt
// - id_rd      in   REG_AW   ID destination (already RegDst-muxed)
// - id_wr      in   1        ID instruction writes the register file (RegWrite)
// - id_load    in   1        ID instruction is a load (MemRead)
// - br_taken   in   1        branch at BR_STAGE taken (Branch & ZF)
// - stall      out  1        hold PC and IF/ID; bubble into ID/EX
// - flush      out  1        kill IF/ID and scoreboard entries younger than BR_STAGE
// - fwd_a      out  2        EX operand A select: 00 regfile, 01 MEM result, 10 WB result
// - fwd_b      out  2        EX operand B select, same encoding
// - stall_cnt  out  CNT_W    cycles with stall=1, saturating
// - flush_cnt  out  CNT_W    cycles with flush=1, saturating
// BEHAVIOUR
// - Entry fields: {valid, wr, load, rd, rs, rt, use_rs, use_rt}.
// - Every edge, entries shift toward WB; the oldest entry is dropped.
// - Entry 0 loads the ID instruction when id_valid & ~stall & ~flush; otherwise it loads a bubble.
// - Match(src, e): e.valid & e.wr & e.rd==src & src!=0. Register $0 never causes a hazard.
// - Without FORWARD_EN: stall = id_valid & ~flush & (a used src matches any entry idx 0..STAGES-2).
//   - WB (last idx) never stalls: the bank writes before read in the same cycle.
// - flush = br_taken. On flush, entries idx<BR_STAGE are invalidated at the edge.
// - Flush beats stall in the same cycle: stall forced 0 and the ID instruction is not captured.
// - stall and flush are combinational, same cycle as the inputs; zero cycles of added latency.
// - Load-use without forwarding: stall for 2 cycles. ALU-use: stall for 2 cycles.
// - fwd_a/fwd_b: 00 unless FORWARD_EN; always 00 when entry 0 is invalid.
// - Counters increment at the edge when their signal is 1 and hold at 2^CNT_W-1.
// - Reset: all entries invalid; stall=0, flush=0, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0.
//   - Erst mid-stall clears the stall on the next cycle; Erst has priority over all updates.
// CONFIGURATION
// - FORWARD_EN defined: stall only on load-use, i.e. entry 0 valid & load & matches a used ID src.
//   - EX operands resolve by priority MEM (idx1, 01) over WB (idx2, 10); loads at idx1 are not forwarded.
//   - An idx1 load needs no rule: the load-use stall already separates it.
// - FORWARD_EN undefined: full-interlock stall rule above; fwd_a=fwd_b=00 constantly.
// TESTING
// - Reset: hold Erst 2 cycles with random inputs -> all outputs 0, counters 0.
// - No FORWARD_EN: add $3 then sub using $3 -> stall=1 for 2 cycles, stall_cnt=2, fwd=00.
// - FORWARD_EN: add $3 then sub rs=$3 -> stall=0, next cycle fwd_a=01.
//   - Same with one independent instr between -> fwd_a=10.
// - FORWARD_EN: lw $4 then add rt=$4 -> stall=1 exactly 1 cycle, then fwd_b=10.
// - Write to $0 followed by a reader of $0 -> stall=0, fwd=00 in both configs.
// - Branch taken with a pending hazard: br_taken=1 while ID would stall -> flush=1, stall=0.
//   - Entry 0 becomes a bubble and flush_cnt increments by 1.
// - Saturation: CNT_W=4 with stall held 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: RAW stall, branch flush, EX forwarding select.
// Optional operand forwarding is compiled in when FORWARD_EN is defined.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int STAGES   = 3,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              Eclk,
  input  logic              Erst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } entry_t;

  entry_t            sb_reg  [STAGES];
  entry_t            sb_next [STAGES];
  entry_t            id_entry;
  logic [STAGES-1:0] hit_rs;
  logic [STAGES-1:0] hit_rt;
  logic              raw_hazard;
  logic              capture;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  // $0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic raw_match(input logic [REG_AW-1:0] src, input entry_t e);
    return e.valid && e.wr && (e.rd == src) && (src != '0);
  endfunction

  function automatic entry_t kill(input entry_t e);
    entry_t r;
    r       = e;
    r.valid = 1'b0;
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_hit
      assign hit_rs[gi] = id_use_rs & raw_match(id_rs, sb_reg[gi]);
      assign hit_rt[gi] = id_use_rt & raw_match(id_rt, sb_reg[gi]);
    end
  endgenerate

`ifdef FORWARD_EN
  assign raw_hazard = sb_reg[0].load & (hit_rs[0] | hit_rt[0]);
`else
  // The WB entry is excluded: the register bank writes before it is read.
  assign raw_hazard = |(hit_rs[STAGES-2:0] | hit_rt[STAGES-2:0]);
`endif

  assign flush   = br_taken & ~Erst;
  assign stall   = id_valid & ~flush & ~Erst & raw_hazard;
  assign capture = id_valid & ~stall & ~flush;

  assign id_entry   = {1'b1, id_wr, id_load, id_rd, id_rs, id_rt, id_use_rs, id_use_rt};
  assign sb_next[0] = capture ? id_entry : '0;

  // Entries younger than the resolving branch are wrong-path and die as they shift.
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_shift
      if (gi <= BR_STAGE) begin : g_young
        assign sb_next[gi] = flush ? kill(sb_reg[gi-1]) : sb_reg[gi-1];
      end else begin : g_old
        assign sb_next[gi] = sb_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge Eclk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (Erst) begin
        sb_reg[i] <= '0;
      end else begin
        sb_reg[i] <= sb_next[i];
      end
    end
  end

  always_ff @(posedge Eclk) begin
    if (Erst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (flush && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

`ifdef FORWARD_EN
  // MEM beats WB; a load in MEM has no data yet, and load-use stalls keep that case away.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src, input logic use_src,
                                         input entry_t ex, input entry_t mem, input entry_t wb);
    if (!ex.valid || !use_src) return 2'b00;
    if (!mem.load && raw_match(src, mem)) return 2'b01;
    if (raw_match(src, wb)) return 2'b10;
    return 2'b00;
  endfunction

  assign fwd_a = Erst ? 2'b00 :
                 fwd_sel(sb_reg[0].rs, sb_reg[0].use_rs, sb_reg[0], sb_reg[1], sb_reg[2]);
  assign fwd_b = Erst ? 2'b00 :
                 fwd_sel(sb_reg[0].rt, sb_reg[0].use_rt, sb_reg[0], sb_reg[1], sb_reg[2]);
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  logic unused_ok;
  assign unused_ok = ^{hit_rs, hit_rt, sb_reg[STAGES-1]};

endmodule
